// File: rtl/qam_pkg.sv
// Shared types and constants for the 16QAM per-rail demodulator slice.
//   SYM_W        width of one rail's amplitude code
//   sym_t        2-bit amplitude code type
//   SYM_*        amplitude codes: 0=-1/2, 1=-1/6, 2=+1/6, 3=+1/2
//   THR_MUL      slicer threshold factor (decision boundary at E/3)
//   state_t      symbol-framing FSM states
package qam_pkg;

    localparam int unsigned SYM_W = 2;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t SYM_N1_2 = 2'd0;
    localparam sym_t SYM_N1_6 = 2'd1;
    localparam sym_t SYM_P1_6 = 2'd2;
    localparam sym_t SYM_P1_2 = 2'd3;

    localparam int unsigned THR_MUL = 3;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

endpackage

// File: rtl/qam_demod_slicer_if.sv
// Sample-in / symbol-out bundle of the per-rail demodulator.
//   master: drives sample_valid, rx_sample, carrier, sym_start; observes results
//   slave : the demodulator; drives sym_valid, symbol, metric, sync_err
interface qam_demod_slicer_if #(
    parameter int unsigned ACC_W = 19
);
    import qam_pkg::*;

    logic                    sample_valid;
    logic signed [7:0]       rx_sample;
    logic signed [7:0]       carrier;
    logic                    sym_start;
    logic                    sym_valid;
    sym_t                    symbol;
    logic signed [ACC_W-1:0] metric;
    logic                    sync_err;

    modport master (
        output sample_valid, rx_sample, carrier, sym_start,
        input  sym_valid, symbol, metric, sync_err
    );

    modport slave (
        input  sample_valid, rx_sample, carrier, sym_start,
        output sym_valid, symbol, metric, sync_err
    );

endinterface

// File: rtl/qam_corr_acc.sv
// Two-stage multiply-accumulate for one symbol's correlation and carrier energy.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            sample/carrier valid this cycle
//   in_first, in_last   sample is index 0 / index SPS-1 of the symbol
//   rx_sample, carrier  signed 8-bit operands
//   acc, energy         running correlation and energy sums
//   sum_valid           one-cycle pulse: acc/energy hold a completed symbol
module qam_corr_acc #(
    parameter int unsigned ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [7:0]       rx_sample,
    input  logic signed [7:0]       carrier,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] energy,
    output logic                    sum_valid
);

    logic signed [15:0]      prod_q, en_q;
    logic                    v_q, first_q, last_q;
    logic signed [ACC_W-1:0] acc_q, en_acc_q;
    logic                    done_q;
    logic signed [ACC_W-1:0] prod_x, en_x;

    // S1: products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            en_q    <= '0;
            v_q     <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            v_q     <= in_valid;
            first_q <= in_valid && in_first;
            last_q  <= in_valid && in_last;
            if (in_valid) begin
                prod_q <= rx_sample * carrier;
                en_q   <= carrier * carrier;
            end
        end
    end

    assign prod_x = {{(ACC_W-16){prod_q[15]}}, prod_q};
    assign en_x   = {{(ACC_W-16){en_q[15]}}, en_q};

    // S2: accumulate; a first-flagged product overwrites any partial sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            en_acc_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= v_q && last_q;
            if (v_q) begin
                acc_q    <= first_q ? prod_x : acc_q + prod_x;
                en_acc_q <= first_q ? en_x : en_acc_q + en_x;
            end
        end
    end

    assign acc       = acc_q;
    assign energy    = en_acc_q;
    assign sum_valid = done_q;

endmodule

// File: rtl/qam_demod_slicer.sv
// Coherent 4-PAM demodulator for one 16QAM rail: carrier correlation over one
// symbol followed by an energy-normalised 4-level slicer.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  sample_valid/rx_sample/carrier/sym_start in;
//                sym_valid/symbol/metric/sync_err out
module qam_demod_slicer
    import qam_pkg::*;
#(
    parameter int unsigned SPS   = 8,
    parameter int unsigned ACC_W = 16 + $clog2(SPS)
) (
    input logic               clk,
    input logic               rst_n,
    qam_demod_slicer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SPS);
    localparam logic signed [ACC_W+1:0] THR = (ACC_W+2)'(THR_MUL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, idx;
    logic             take, first, last, resync;
    logic             sync_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx     = cnt_q;
        take    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        resync  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.sample_valid && bus.sym_start) begin
                    state_d = StRun;
                    take    = 1'b1;
                    idx     = '0;
                end
            end
            StRun: begin
                if (bus.sample_valid) begin
                    take = 1'b1;
                    if (bus.sym_start) begin
                        // Mid-symbol start: drop the partial symbol, realign here
                        resync = (cnt_q != '0);
                        idx    = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            first = (idx == '0);
            last  = (idx == CNT_W'(SPS-1));
            cnt_d = last ? '0 : idx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_err_q <= resync;
        end
    end

    logic signed [ACC_W-1:0] acc, energy;
    logic                    sum_valid;

    qam_corr_acc #(
        .ACC_W (ACC_W)
    ) u_corr_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (take),
        .in_first  (first),
        .in_last   (last),
        .rx_sample (bus.rx_sample),
        .carrier   (bus.carrier),
        .acc       (acc),
        .energy    (energy),
        .sum_valid (sum_valid)
    );

    // Slicer: decision boundaries at 0 and +/-E/3, compared as 3*acc vs E
    logic signed [ACC_W+1:0] acc_x, en_x, acc3;
    sym_t                    slice;

    assign acc_x = {{2{acc[ACC_W-1]}}, acc};
    assign en_x  = {{2{energy[ACC_W-1]}}, energy};
    assign acc3  = acc_x * THR;

    always_comb begin
        slice = SYM_N1_2;
        if (acc3 >= en_x) begin
            slice = SYM_P1_2;
        end else if (!acc_x[ACC_W+1]) begin
            slice = SYM_P1_6;
        end else if (acc3 >= -en_x) begin
            slice = SYM_N1_6;
        end
    end

    // S3: register decision; symbol/metric hold between pulses
    logic                    sym_valid_q;
    sym_t                    symbol_q;
    logic signed [ACC_W-1:0] metric_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid_q <= 1'b0;
            symbol_q    <= SYM_N1_2;
            metric_q    <= '0;
        end else begin
            sym_valid_q <= sum_valid;
            if (sum_valid) begin
                symbol_q <= slice;
                metric_q <= acc;
            end
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.symbol    = symbol_q;
    assign bus.metric    = metric_q;
    assign bus.sync_err  = sync_err_q;

endmodule
